// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the 640x480@60 Hz VGA path.
// Default segment lengths are in pixels (horizontal) and lines (vertical).
package vga_pkg;

    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;

    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;

    localparam int unsigned H_TOTAL     = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned V_TOTAL     = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned H_ACT_START = H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE_DEF - 1;
    localparam int unsigned V_ACT_START = V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE_DEF - 1;

    // {R[3:0], G[3:0], B[3:0]}
    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/pix_strobe.sv
// Pixel-rate strobe: one-clk pulse every CLK_DIV system clocks.
// With CLK_DIV=1 the strobe is constantly high.
module pix_strobe #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (div == DIV_LAST)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign pix_en = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing: divider, h/v counters, active-window decode, frame tick
// and the registered sync/colour pin stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  rgb12_t     rgb_in,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_SYN_HI = 10'(H_SYNC);
    localparam logic [9:0] V_SYN_HI = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic h_last;
    logic v_last;
    logic hsync_next;
    logic vsync_next;

    pix_strobe #(.CLK_DIV(CLK_DIV)) u_pix_strobe (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    always_comb begin
        h_last     = (hCount == H_LAST);
        v_last     = (vCount == V_LAST);
        bright     = (hCount >= H_ACT_LO) && (hCount <= H_ACT_HI) &&
                     (vCount >= V_ACT_LO) && (vCount <= V_ACT_HI);
        hsync_next = (hCount >= H_SYN_HI);
        vsync_next = (vCount >= V_SYN_HI);
        frame_tick = pix_en && h_last && v_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount <= '0;
            vCount <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hCount <= '0;
                vCount <= v_last ? '0 : vCount + 10'd1;
            end else begin
                hCount <= hCount + 10'd1;
            end
        end
    end

    // Sync and colour share one capture so the pins stay mutually aligned;
    // blanking is forced here regardless of what the draw logic supplies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_en) begin
            hsync <= hsync_next;
            vsync <= vsync_next;
            {vga_r, vga_g, vga_b} <= bright ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: per-cycle comparison against a time-based timing model,
// plus directed literal checks, on a full-size and a reduced-geometry instance.
module tb_vga_timing_gen;

    typedef struct {
        int unsigned d, hs, hbp, ha, hfp, vs, vbp, va, vfp;
    } geom_t;

    typedef struct {
        logic [9:0]  hc, vc;
        logic        bright, pix_en, ft, hs, vs;
        logic [11:0] rgb;
    } exp_t;

    localparam geom_t GA = '{4, 96, 48, 640, 16, 2, 33, 480, 10};
    localparam geom_t GB = '{4, 8, 6, 16, 6, 2, 3, 5, 3};
    localparam int unsigned FRAME_B = 36 * 13 * 4;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic chk_on = 1'b0;
    int unsigned mode_a = 0;
    int unsigned mode_b = 0;
    int unsigned n_a, n_b;

    logic [11:0] rgb_a, rgb_b;
    logic [9:0]  hc_a, vc_a, hc_b, vc_b;
    logic        br_a, pe_a, ft_a, hs_a, vs_a;
    logic        br_b, pe_b, ft_b, hs_b, vs_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    always #5 clk = ~clk;

    // Draw-logic stand-in: colour as a function of the current position.
    function automatic logic [11:0] pat(input int unsigned mode, input logic [9:0] h, input logic [9:0] v);
        if (mode == 1)
            return 12'hF00;
        return {h[3:0], v[3:0], h[7:4]};
    endfunction

    function automatic logic in_win(input int unsigned x, input int unsigned lo, input int unsigned len);
        return (x >= lo) && (x < lo + len);
    endfunction

    // Outputs after n clock edges since reset release.
    function automatic exp_t model(input geom_t g, input int unsigned n, input int unsigned mode);
        exp_t e;
        int unsigned ht, vt, p, hc, vc, q, qh, qv;
        ht = g.hs + g.hbp + g.ha + g.hfp;
        vt = g.vs + g.vbp + g.va + g.vfp;
        p  = n / g.d;
        hc = p % ht;
        vc = (p / ht) % vt;
        e.hc     = 10'(hc);
        e.vc     = 10'(vc);
        e.pix_en = (n % g.d) == (g.d - 1);
        e.bright = in_win(hc, g.hs + g.hbp, g.ha) && in_win(vc, g.vs + g.vbp, g.va);
        e.ft     = e.pix_en && (hc == ht - 1) && (vc == vt - 1);
        if (p == 0) begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.rgb = 12'h000;
        end else begin
            q  = p - 1;
            qh = q % ht;
            qv = (q / ht) % vt;
            e.hs  = (qh >= g.hs);
            e.vs  = (qv >= g.vs);
            e.rgb = (in_win(qh, g.hs + g.hbp, g.ha) && in_win(qv, g.vs + g.vbp, g.va))
                    ? pat(mode, 10'(qh), 10'(qv)) : 12'h000;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_cycle(input string name, input exp_t e, input int unsigned n,
                               input logic [9:0] hc, input logic [9:0] vc, input logic br,
                               input logic pe, input logic ft, input logic hs, input logic vs,
                               input logic [11:0] rgb);
        vectors++;
        if (hc !== e.hc || vc !== e.vc || br !== e.bright || pe !== e.pix_en ||
            ft !== e.ft || hs !== e.hs || vs !== e.vs || rgb !== e.rgb) begin
            miscompares++;
            $display("FAIL %s_cycle n=%0d: got hc=%0d vc=%0d br=%b pe=%b ft=%b hs=%b vs=%b rgb=%h, required hc=%0d vc=%0d br=%b pe=%b ft=%b hs=%b vs=%b rgb=%h",
                     name, n, hc, vc, br, pe, ft, hs, vs, rgb,
                     e.hc, e.vc, e.bright, e.pix_en, e.ft, e.hs, e.vs, e.rgb);
        end
    endtask

    assign rgb_a = pat(mode_a, hc_a, vc_a);
    assign rgb_b = pat(mode_b, hc_b, vc_b);

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .rgb_in(rgb_a),
        .hCount(hc_a), .vCount(vc_a), .bright(br_a), .pix_en(pe_a), .frame_tick(ft_a),
        .hsync(hs_a), .vsync(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_SYNC(8), .H_BP(6), .H_ACTIVE(16), .H_FP(6),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(5), .V_FP(3)
    ) dut_b (
        .clk(clk), .rst(rst_b), .rgb_in(rgb_b),
        .hCount(hc_b), .vCount(vc_b), .bright(br_b), .pix_en(pe_b), .frame_tick(ft_b),
        .hsync(hs_b), .vsync(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    always @(posedge clk or posedge rst_a)
        if (rst_a) n_a <= 0; else n_a <= n_a + 1;
    always @(posedge clk or posedge rst_b)
        if (rst_b) n_b <= 0; else n_b <= n_b + 1;

    always @(negedge clk)
        if (chk_on)
            check_cycle("A", model(GA, n_a, mode_a), n_a, hc_a, vc_a, br_a, pe_a, ft_a, hs_a, vs_a, {r_a, g_a, b_a});

    int unsigned cyc_b = 0;
    int unsigned last_ft = 0;
    logic        last_ft_ok = 1'b0;
    int unsigned ft_seen = 0;

    always @(negedge clk) begin
        cyc_b++;
        if (chk_on) begin
            check_cycle("B", model(GB, n_b, mode_b), n_b, hc_b, vc_b, br_b, pe_b, ft_b, hs_b, vs_b, {r_b, g_b, b_b});
            if (rst_b)
                last_ft_ok = 1'b0;
            else if (ft_b === 1'b1) begin
                if (last_ft_ok)
                    check("frame_tick_spacing", 32'(cyc_b - last_ft), 32'(FRAME_B));
                last_ft    = cyc_b;
                last_ft_ok = 1'b1;
                ft_seen++;
            end
        end
    end

    task automatic wait_a(input int unsigned h, input int unsigned v);
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (hc_a == 10'(h) && vc_a == 10'(v) && pe_a) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_A: position (%0d,%0d) not reached, required within 8000 clk", h, v);
    endtask

    task automatic wait_b(input int unsigned h, input int unsigned v);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (hc_b == 10'(h) && vc_b == 10'(v) && pe_b) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_B: position (%0d,%0d) not reached, required within 4000 clk", h, v);
    endtask

    initial begin
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (5) @(negedge clk);

        check("reset_hcount", 32'(hc_a), 32'd0);
        check("reset_hsync", 32'(hs_a), 32'd1);
        check("reset_vsync", 32'(vs_a), 32'd1);
        check("reset_pix_en", 32'(pe_a), 32'd0);
        check("reset_rgb", 32'({r_a, g_a, b_a}), 32'd0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("strobe_4th_cycle", 32'(pe_a), 32'd1);
        check("hcount_before_4th_edge", 32'(hc_a), 32'd0);
        @(posedge clk);
        #1;
        check("hcount_after_4th_edge", 32'(hc_a), 32'd1);
        check("strobe_after_4th_edge", 32'(pe_a), 32'd0);

        fork
            begin : track_a
                int unsigned lows;
                wait_a(799, 0);
                @(posedge clk);
                #1;
                check("hwrap_hcount", 32'(hc_a), 32'd0);
                check("hwrap_vcount", 32'(vc_a), 32'd1);
                lows = 0;
                repeat (3200) begin
                    @(negedge clk);
                    if (hs_a == 1'b0) lows++;
                end
                check("hsync_low_clks_per_line", 32'(lows), 32'd384);
            end
            begin : track_b
                wait_b(13, 5);
                check("bright_left_edge_minus1", 32'(br_b), 32'd0);
                wait_b(14, 5);
                check("bright_first_active", 32'(br_b), 32'd1);
                wait_b(30, 6);
                check("bright_past_right_edge", 32'(br_b), 32'd0);
                wait_b(14, 10);
                check("bright_below_window", 32'(br_b), 32'd0);

                for (int i = 0; i < 3 * FRAME_B + 200 && ft_seen < 3; i++)
                    @(negedge clk);
                check("frame_ticks_seen", 32'(ft_seen), 32'd3);

                // Reset in the middle of pixel (20,7).
                wait_b(19, 7);
                @(posedge clk);
                @(posedge clk);
                #2;
                rst_b = 1'b1;
                #1;
                check("midreset_hcount", 32'(hc_b), 32'd0);
                check("midreset_vcount", 32'(vc_b), 32'd0);
                check("midreset_hsync", 32'(hs_b), 32'd1);
                check("midreset_vsync", 32'(vs_b), 32'd1);
                check("midreset_rgb", 32'({r_b, g_b, b_b}), 32'd0);
                mode_b = 1;
                repeat (5) @(negedge clk);
                rst_b = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("restart_strobe", 32'(pe_b), 32'd1);
                @(posedge clk);
                #1;
                check("restart_hcount", 32'(hc_b), 32'd1);

                wait_b(10, 5);
                @(posedge clk);
                #1;
                check("colour_blanked_r", 32'(r_b), 32'd0);
                wait_b(14, 5);
                @(posedge clk);
                #1;
                check("colour_active_r", 32'(r_b), 32'hF);
                check("colour_active_g", 32'(g_b), 32'd0);
                wait_b(35, 1);
                @(posedge clk);
                #1;
                check("vsync_line1_low", 32'(vs_b), 32'd0);
                wait_b(0, 2);
                @(posedge clk);
                #1;
                check("vsync_line2_high", 32'(vs_b), 32'd1);
            end
        join

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
